// File: rtl/parity_rx_pkg.sv
// Shared constants and the parity-check helper for the parity_rx receiver.
// Optional build macro used by parity_rx: PARITY_RX_DROP_BAD_EN.
package parity_rx_pkg;

    localparam int unsigned ERR_CNT_W  = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Widest word the check must handle: 32 payload bits plus the parity bit.
    localparam int unsigned MAX_WORD_W = 33;

    // Word is good when the XOR over every bit (payload and parity) matches
    // the selected sense: 0 for even parity, 1 for odd parity.
    function automatic logic parity_ok(input logic [MAX_WORD_W-1:0] word,
                                       input logic                  odd);
        return ((^word) == odd);
    endfunction

endpackage

// File: rtl/parity_rx_fifo.sv
// Synchronous first-word-fall-through buffer used by parity_rx.
// Head entry is visible on rd_data whenever empty is low.
module parity_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/parity_rx.sv
// Parity-checking receiver: checks each accepted word, buffers payload plus
// check result in a FWFT buffer, and counts bad words with a sticky flag.
// Build macro PARITY_RX_DROP_BAD_EN: bad words are counted but not buffered.
module parity_rx
    import parity_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W:0]      in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_ok,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 err_sticky
);

    logic [MAX_WORD_W-1:0] word_ext;
    logic                  word_ok;
    logic                  accept;
    logic                  bad_accept;
    logic                  wr_en;
    logic                  full;
    logic                  empty;
    logic [DATA_W:0]       rd_data;

    // Zero-extend the incoming word so the shared check works for any DATA_W.
    always_comb begin
        word_ext           = '0;
        word_ext[DATA_W:0] = in_data;
    end

    assign word_ok    = parity_ok(word_ext, (PARITY_ODD != 0));
    assign accept     = in_valid && in_ready;
    assign bad_accept = accept && !word_ok;
    assign in_ready   = !full;
    assign out_valid  = !empty;
    assign out_data   = rd_data[DATA_W-1:0];

`ifdef PARITY_RX_DROP_BAD_EN
    assign wr_en  = accept && word_ok;
    assign out_ok = 1'b1;
`else
    assign wr_en  = accept;
    assign out_ok = rd_data[DATA_W];
`endif

    parity_rx_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data ({word_ok, in_data[DATA_W-1:0]}),
        .rd_en   (out_ready),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    // Saturating bad-word counter; a clear coinciding with a bad accept
    // restarts the count at one instead of zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr_err) begin
            err_count  <= bad_accept ? ERR_CNT_W'(1) : '0;
            err_sticky <= bad_accept;
        end else if (bad_accept) begin
            if (err_count != ERR_CNT_MAX) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
            err_sticky <= 1'b1;
        end
    end

endmodule
